// File: rtl/uvma_cvmcu_intr_ctrl.sv
// Interrupt controller for the CORE-V MCU interrupt interface: pending register,
// enable mask, fixed-priority selection and an irq/irq_id/irq_ack handshake FSM.
module uvma_cvmcu_intr_ctrl #(
  parameter int NUM_SRC = 32,
  parameter int ID_W    = $clog2(NUM_SRC),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] edge_mode_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic [NUM_SRC-1:0] sw_set_i,
  input  logic [NUM_SRC-1:0] sw_clr_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               spurious_ack_o,
  output logic [CNT_W-1:0]   irq_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               spurious_q, spurious_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [NUM_SRC-1:0] event_w;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] cand;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic               ack_fire;
  logic               cur_pending;
  logic               cur_enabled;

  // Set terms dominate clear terms so an event coinciding with its own ack is kept.
  always_comb begin
    event_w  = (src_i & ~src_q & edge_mode_i) | (src_i & ~edge_mode_i);
    ack_fire = (state_q == REQ) && irq_ack_i;
    ack_clr  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_fire && (irq_id_q == ID_W'(i));
    end
    pending_d = (pending_q & ~(sw_clr_i | ack_clr)) | event_w | sw_set_i;
  end

  // Lowest index wins; scanning downward lets the last hit be the lowest one.
  always_comb begin
    cand       = pending_q & en_i;
    cand_valid = |cand;
    cand_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    cur_pending = 1'b0;
    cur_enabled = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_id_q == ID_W'(i)) begin
        cur_pending = pending_q[i];
        cur_enabled = en_i[i];
      end
    end
  end

  // Handshake sequencing; ack takes precedence over a withdraw in the same cycle.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    count_d    = count_q;
    spurious_d = irq_ack_i && (state_q != REQ);
    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          irq_id_d = cand_id;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = GAP;
          irq_d   = 1'b0;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (!cur_pending || !cur_enabled) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      spurious_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_i;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      spurious_q <= spurious_d;
      count_q    <= count_d;
    end
  end

  assign irq_o          = irq_q;
  assign irq_id_o       = irq_id_q;
  assign pending_o      = pending_q;
  assign spurious_ack_o = spurious_q;
  assign irq_count_o    = count_q;

endmodule
